// File: rtl/window_gen.sv
// Streaming 6x6 window generator: five cascaded line buffers feed a 6x6 shift window.
// Define WINGEN_ERR_EN to add the sticky frame_err_o flag for unexpected sof.
module window_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pix_valid_i,
  input  logic [7:0]             pix_data_i,
  input  logic                   sof_i,
  output logic [0:5][0:5][7:0]   window_o,
  output logic                   win_valid_o,
`ifdef WINGEN_ERR_EN
  output logic                   frame_err_o,
`endif
  output logic                   frame_done_o
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [CW-1:0]         col_q, col_d, curCol;
  logic [RW-1:0]         row_q, row_d, curRow;
  logic                  lastCol, lastRow;
  logic [7:0]            lb_q [0:4][0:IMG_WIDTH-1];
  logic [7:0]            cv [0:5];
  logic [0:5][0:5][7:0]  window_q;
  logic                  winValid_q;
  logic                  frameDone_q;

  // An accepted sof overrides the counters so this pixel is treated as (0,0).
  always_comb begin
    curCol  = sof_i ? '0 : col_q;
    curRow  = sof_i ? '0 : row_q;
    lastCol = (curCol == CW'(IMG_WIDTH - 1));
    lastRow = (curRow == RW'(IMG_HEIGHT - 1));
    col_d   = col_q;
    row_d   = row_q;
    if (pix_valid_i) begin
      if (lastCol) begin
        col_d = '0;
        row_d = lastRow ? '0 : curRow + RW'(1);
      end else begin
        col_d = curCol + CW'(1);
        row_d = curRow;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cv[i] = lb_q[i][curCol];
    end
    cv[5] = pix_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers are deliberately not reset; win_valid gating hides stale contents.
  always_ff @(posedge clk) begin
    if (!reset && pix_valid_i) begin
      for (int k = 0; k < 5; k++) begin
        lb_q[k][curCol] <= cv[k+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      window_q    <= '0;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
      if (pix_valid_i) begin
        for (int i = 0; i < 6; i++) begin
          window_q[i][0:4] <= window_q[i][1:5];
          window_q[i][5]   <= cv[i];
        end
        winValid_q  <= (curRow >= RW'(5)) && (curCol >= CW'(5));
        frameDone_q <= lastRow && lastCol;
      end
    end
  end

`ifdef WINGEN_ERR_EN
  logic frameErr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frameErr_q <= 1'b0;
    end else if (pix_valid_i && sof_i && ((row_q != '0) || (col_q != '0))) begin
      frameErr_q <= 1'b1;
    end
  end

  assign frame_err_o = frameErr_q;
`endif

  assign window_o     = window_q;
  assign win_valid_o  = winValid_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_window_gen.sv
// Self-checking bench for window_gen on an 8x8 image against a frame-array reference model.
// Covers reset, full frames, gapped input, row boundary, back-to-back, mid-frame sof and mid-frame reset.
module tb_window_gen;

  localparam int W = 8;
  localparam int H = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  pix_valid_i = 1'b0;
  logic [7:0]            pix_data_i = '0;
  logic                  sof_i = 1'b0;
  logic [0:5][0:5][7:0]  window_o;
  logic                  win_valid_o;
  logic                  frame_done_o;
`ifdef WINGEN_ERR_EN
  logic                  frame_err_o;
`endif

  int passCnt = 0;
  int checkCnt = 0;

  // Reference model: the current frame as a plain image plus the expected position.
  logic [7:0]            img [0:H-1][0:W-1];
  int                    mRow = 0;
  int                    mCol = 0;
  logic [0:5][0:5][7:0]  expWin = '0;
  logic                  expValid = 1'b0;
  logic                  expDone = 1'b0;
  logic                  expErr = 1'b0;
  bit                    winKnown = 1'b1;

  window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid_i  (pix_valid_i),
    .pix_data_i   (pix_data_i),
    .sof_i        (sof_i),
    .window_o     (window_o),
    .win_valid_o  (win_valid_o),
`ifdef WINGEN_ERR_EN
    .frame_err_o  (frame_err_o),
`endif
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle, then advance the model to what the outputs must show after the edge.
  task automatic applyStimulus(input bit rst, input bit v, input bit s, input logic [7:0] d);
    reset       = rst;
    pix_valid_i = v;
    sof_i       = s;
    pix_data_i  = d;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
    if (rst) begin
      mRow = 0; mCol = 0;
      expErr = 1'b0; expWin = '0; winKnown = 1'b1;
      expValid = 1'b0; expDone = 1'b0;
    end else if (v) begin
      if (s) begin
        if (mRow != 0 || mCol != 0) expErr = 1'b1;
        mRow = 0; mCol = 0;
      end
      img[mRow][mCol] = d;
      expValid = (mRow >= 5) && (mCol >= 5);
      expDone  = (mRow == H-1) && (mCol == W-1);
      winKnown = expValid;
      if (expValid) begin
        for (int a = 0; a < 6; a++)
          for (int b = 0; b < 6; b++)
            expWin[a][b] = img[mRow-5+a][mCol-5+b];
      end
      mCol++;
      if (mCol == W) begin
        mCol = 0;
        mRow = (mRow == H-1) ? 0 : mRow + 1;
      end
    end else begin
      expValid = 1'b0;
      expDone  = 1'b0;
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkCnt++; if (win_valid_o !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", win_valid_o); else passCnt++;
    checkCnt++; if (frame_done_o !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", frame_done_o); else passCnt++;
    checkCnt++; if (window_o !== '0) $display("[TB] FAIL reset_window got %h want 0", window_o); else passCnt++;
`ifdef WINGEN_ERR_EN
    checkCnt++; if (frame_err_o !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", frame_err_o); else passCnt++;
`endif
  endtask

  task automatic test_basic_frame();
    int wins = 0;
    bit firstSeen = 0;
    for (int p = 0; p < W*H; p++) begin
      applyStimulus(1'b0, 1'b1, p == 0, 8'(p));
      checkCnt++; if (win_valid_o !== expValid) $display("[TB] FAIL basic_valid p=%0d got %b want %b", p, win_valid_o, expValid); else passCnt++;
      checkCnt++; if (frame_done_o !== expDone) $display("[TB] FAIL basic_done p=%0d got %b want %b", p, frame_done_o, expDone); else passCnt++;
      if (win_valid_o) begin
        wins++;
        checkCnt++; if (window_o !== expWin) $display("[TB] FAIL basic_window p=%0d got %h want %h", p, window_o, expWin); else passCnt++;
        if (!firstSeen) begin
          firstSeen = 1;
          checkCnt++; if (window_o[0][0] !== 8'd0 || window_o[5][5] !== 8'd45) $display("[TB] FAIL basic_first got %0d/%0d want 0/45", window_o[0][0], window_o[5][5]); else passCnt++;
        end
      end
      if (frame_done_o) begin
        checkCnt++; if (window_o[5][5] !== 8'd63) $display("[TB] FAIL basic_done_pix got %0d want 63", window_o[5][5]); else passCnt++;
      end
    end
    checkCnt++; if (wins != 9) $display("[TB] FAIL basic_count got %0d want 9", wins); else passCnt++;
  endtask

  task automatic test_gapped();
    int wins = 0;
    int accepted = 0;
    while (accepted < W*H) begin
      bit v = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, v, v && accepted == 0, 8'($urandom));
      if (v) accepted++;
      checkCnt++; if (win_valid_o !== expValid) $display("[TB] FAIL gap_valid a=%0d got %b want %b", accepted, win_valid_o, expValid); else passCnt++;
      checkCnt++; if (frame_done_o !== expDone) $display("[TB] FAIL gap_done a=%0d got %b want %b", accepted, frame_done_o, expDone); else passCnt++;
      if (winKnown) begin
        checkCnt++; if (window_o !== expWin) $display("[TB] FAIL gap_window a=%0d got %h want %h", accepted, window_o, expWin); else passCnt++;
      end
      if (win_valid_o) wins++;
    end
    checkCnt++; if (wins != 9) $display("[TB] FAIL gap_count got %0d want 9", wins); else passCnt++;
  endtask

  task automatic test_row_boundary();
    for (int p = 0; p < W*H; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'(p));
      if (p >= 48 && p <= 52) begin
        checkCnt++; if (win_valid_o !== 1'b0) $display("[TB] FAIL row_novalid p=%0d got %b want 0", p, win_valid_o); else passCnt++;
      end
      if (p == 53) begin
        checkCnt++; if (win_valid_o !== 1'b1) $display("[TB] FAIL row_valid got %b want 1", win_valid_o); else passCnt++;
        checkCnt++; if (window_o[0][0] !== 8'd8 || window_o[5][0] !== 8'd48) $display("[TB] FAIL row_window got %0d/%0d want 8/48", window_o[0][0], window_o[5][0]); else passCnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] data [0:W*H-1];
    int wins = 0;
    int dones = 0;
    for (int p = 0; p < W*H; p++) data[p] = 8'($urandom);
    for (int p = 0; p < 2*W*H; p++) begin
      applyStimulus(1'b0, 1'b1, p == 0, data[p % (W*H)]);
      checkCnt++; if (win_valid_o !== expValid) $display("[TB] FAIL b2b_valid p=%0d got %b want %b", p, win_valid_o, expValid); else passCnt++;
      checkCnt++; if (frame_done_o !== expDone) $display("[TB] FAIL b2b_done p=%0d got %b want %b", p, frame_done_o, expDone); else passCnt++;
      if (win_valid_o) begin
        wins++;
        checkCnt++; if (window_o !== expWin) $display("[TB] FAIL b2b_window p=%0d got %h want %h", p, window_o, expWin); else passCnt++;
      end
      if (frame_done_o) dones++;
    end
    checkCnt++; if (wins != 18) $display("[TB] FAIL b2b_count got %0d want 18", wins); else passCnt++;
    checkCnt++; if (dones != 2) $display("[TB] FAIL b2b_dones got %0d want 2", dones); else passCnt++;
  endtask

  task automatic test_mid_sof();
    int wins = 0;
    int dones = 0;
    for (int p = 0; p < 26 + W*H; p++) begin
      applyStimulus(1'b0, 1'b1, p == 26, 8'($urandom));
      checkCnt++; if (win_valid_o !== expValid) $display("[TB] FAIL sof_valid p=%0d got %b want %b", p, win_valid_o, expValid); else passCnt++;
      checkCnt++; if (frame_done_o !== expDone) $display("[TB] FAIL sof_done p=%0d got %b want %b", p, frame_done_o, expDone); else passCnt++;
      if (win_valid_o) begin
        wins++;
        checkCnt++; if (window_o !== expWin) $display("[TB] FAIL sof_window p=%0d got %h want %h", p, window_o, expWin); else passCnt++;
      end
      if (frame_done_o) dones++;
`ifdef WINGEN_ERR_EN
      checkCnt++; if (frame_err_o !== expErr) $display("[TB] FAIL sof_err p=%0d got %b want %b", p, frame_err_o, expErr); else passCnt++;
`endif
    end
    checkCnt++; if (wins != 9) $display("[TB] FAIL sof_count got %0d want 9", wins); else passCnt++;
    checkCnt++; if (dones != 1) $display("[TB] FAIL sof_dones got %0d want 1", dones); else passCnt++;
  endtask

  task automatic test_reset_mid_frame();
    int wins = 0;
    for (int p = 0; p < 54; p++) applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom));
    applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom));
    checkCnt++; if (win_valid_o !== 1'b0 || frame_done_o !== 1'b0) $display("[TB] FAIL rstmid_flags got %b%b want 00", win_valid_o, frame_done_o); else passCnt++;
    checkCnt++; if (window_o !== '0) $display("[TB] FAIL rstmid_window got %h want 0", window_o); else passCnt++;
`ifdef WINGEN_ERR_EN
    checkCnt++; if (frame_err_o !== 1'b0) $display("[TB] FAIL rstmid_err got %b want 0", frame_err_o); else passCnt++;
`endif
    for (int p = 0; p < W*H; p++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom));
      checkCnt++; if (win_valid_o !== expValid) $display("[TB] FAIL rstmid_valid p=%0d got %b want %b", p, win_valid_o, expValid); else passCnt++;
      checkCnt++; if (frame_done_o !== expDone) $display("[TB] FAIL rstmid_done p=%0d got %b want %b", p, frame_done_o, expDone); else passCnt++;
      if (win_valid_o) begin
        wins++;
        checkCnt++; if (window_o !== expWin) $display("[TB] FAIL rstmid_win p=%0d got %h want %h", p, window_o, expWin); else passCnt++;
      end
    end
    checkCnt++; if (wins != 9) $display("[TB] FAIL rstmid_count got %0d want 9", wins); else passCnt++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gapped();
    test_row_boundary();
    test_back_to_back();
    test_mid_sof();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/window_gen.md
# window_gen

Streaming 6x6 window generator. It is the producer side of the window interface consumed by the gradient stage. It accepts one 8-bit pixel per cycle in raster order, holds the previous five image rows in line buffers, and presents a registered 6x6 neighbourhood with `win_valid` for every pixel position where the full window lies inside the image. It sits between the pixel source (camera/DMA) and the gradient stage.

## Interface
Parameters:
- `IMG_WIDTH`, default 64: pixels per row. Legal range is 6 or more.
- `IMG_HEIGHT`, default 64: rows per frame. Legal range is 6 or more.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `pix_valid`, input, 1: `pix_data` is accepted this cycle.
- `pix_data`, input, 8: pixel value.
- `sof`, input, 1: start of frame. Qualified by `pix_valid`; marks pixel (0,0).
- `window`, output, 8 x [0:5][0:5]: neighbourhood, indexed `window[row][col]`.
- `win_valid`, output, 1: `window` holds a complete, in-image window.
- `frame_done`, output, 1: one-cycle pulse after the last pixel of a frame is accepted.
- `frame_err`, output, 1: sticky error flag. Present only with `WINGEN_ERR_EN`.

## Operation
- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) give the position of the next pixel to be accepted.
- The counters advance only on `pix_valid`.
- `col` wraps to 0 and increments `row`. After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0.
- `pix_valid && sof` forces the current pixel to be (0,0). The counters then continue from (0,1).
- Five line buffers LB0..LB4, each IMG_WIDTH x 8. On accepted pixel P at column c:
  - Column vector `cv[i]` = LBi[c] for i=0..4, and `cv[5]` = P. The LB read returns the pre-write value.
  - LBk[c] is written with `cv[k+1]` for k=0..4 (cascade).
  - Window shifts left: `window[i][j]` takes `window[i][j+1]` for j<5, and `window[i][5]` takes `cv[i]`.
- Result: after accepting pixel (r,c), `window[a][b]` equals pixel (r-5+a, c-5+b). `window[5][5]` is the newest pixel.
- `win_valid` is registered. It is 1 in the cycle after acceptance of (r,c) when r>=5 and c>=5; otherwise it is 0.
  - Columns carried over from the previous row are always flushed before c reaches 5, so no cross-row window is ever flagged valid.
- When `pix_valid`=0, `window` holds its value and `win_valid` is 0 for that cycle.
- Line buffer contents are not reset. Valid gating guarantees stale data is never flagged.
- Windows per frame: (IMG_WIDTH-5) x (IMG_HEIGHT-5).

## Timing
- Latency: pixel accepted on edge N gives `window`/`win_valid` valid after edge N, i.e. one cycle.
- Throughput: one pixel per cycle, with no backpressure. The consumer must accept every valid window.
- `frame_done`: pulses for one cycle, in the same cycle as the `win_valid` of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Reset values: `window` all 0, `win_valid` 0, `frame_done` 0, `frame_err` 0, `row`=`col`=0.
- Reset mid-frame: next accepted pixel is (0,0) regardless of `sof`. No window is flagged until row 5 / column 5 is reached again.
- `sof` mid-frame: the frame restarts at (0,0). The partial frame produces no `frame_done`.
- `sof` asserted on pixel (0,0) that the counters already expect: no effect, and no error.
- `sof` without `pix_valid`: ignored.
- `reset` has priority over `pix_valid`/`sof` in the same cycle.

## Configuration
- `WINGEN_ERR_EN` defined:
  - `frame_err` port exists.
  - It is set when `pix_valid && sof` arrives while the counters are not at (0,0).
  - It stays 1 until `reset`.
- `WINGEN_ERR_EN` undefined:
  - `frame_err` port and logic are absent.
  - Mid-frame `sof` still restarts the frame silently.

## Test plan
- **Basic frame.** Set IMG_WIDTH=IMG_HEIGHT=8 and drive pixel value 8r+c continuously with `sof` on the first pixel.
  - First `win_valid` follows pixel (5,5), with `window[0][0]`=0 and `window[5][5]`=45.
  - Exactly 9 windows are produced.
  - `frame_done` pulses with the window whose `window[5][5]`=63.
- **Gapped input.** Same frame, with `pix_valid` toggling pseudo-randomly.
  - Identical window sequence.
  - `win_valid` is never high in the cycle after `pix_valid`=0.
  - `window` is stable during gaps.
- **Row boundary.** Check the window emitted after (6,5): `window[0][0]`=8, `window[5][0]`=48.
  - No `win_valid` after pixels (6,0)..(6,4).
- **Back-to-back frames.** Two frames, with `sof` only on the first.
  - 18 windows total and two `frame_done` pulses.
  - The second frame's windows are identical to the first's.
- **Mid-frame sof.** Assert `sof` at pixel (3,2), then stream a full frame.
  - No windows until the new (5,5).
  - Then 9 correct windows.
  - With `WINGEN_ERR_EN`, `frame_err` rises the cycle after and stays 1.
- **Reset mid-frame.** Assert `reset` at pixel (6,6).
  - All outputs read 0 the next cycle.
  - The restarted frame yields 9 correct windows.
